// File: rtl/dvp_capture_rgb565_pkg.sv
// Shared definitions for the DVP RGB565 capture block: FSM encoding,
// counter width and a saturating increment helper.
package dvp_capture_rgb565_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    WAIT_VS  = 2'd2,
    ACTIVE   = 2'd3
  } cap_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dvp_capture_rgb565_if.sv
// Captured-pixel stream from the DVP capture block to its consumer.
interface dvp_capture_rgb565_if;
  import dvp_capture_rgb565_pkg::*;

  // pix_valid qualifies pix_data/pix_x/pix_y for exactly one cycle; there is
  // no ready, the consumer must take every pixel presented (camera cannot stall).
  logic             pix_valid;
  logic [15:0]      pix_data;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;
  logic             frame_end;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, frame_start, frame_end
  );

  modport slave (
    input pix_valid, pix_data, pix_x, pix_y, frame_start, frame_end
  );

endinterface

// File: rtl/dvp_byte_pack.sv
// Pairs consecutive DVP bytes into 16-bit words and flags a line that ends
// on an unpaired byte.
module dvp_byte_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        href,
  input  logic        href_rise,
  input  logic        href_fall,
  input  logic [7:0]  d,
  output logic        pair_valid,
  output logic [15:0] pair_data,
  output logic        odd_err
);

  logic       toggle;
  logic [7:0] hi_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle     <= 1'b0;
      hi_byte    <= 8'h00;
      pair_valid <= 1'b0;
      pair_data  <= 16'h0000;
      odd_err    <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      odd_err    <= 1'b0;
      if (!en) begin
        toggle <= 1'b0;
      end else if (href) begin
        // The first byte of each line always opens a new pair.
        if (href_rise || !toggle) begin
          hi_byte <= d;
          toggle  <= 1'b1;
        end else begin
          pair_data  <= {hi_byte, d};
          pair_valid <= 1'b1;
          toggle     <= 1'b0;
        end
      end else if (href_fall) begin
        odd_err <= toggle;
        toggle  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dvp_capture_rgb565.sv
// DVP camera capture: skips settling frames after sensor configuration, then
// assembles RGB565 pixels with coordinates, frame pulses and fault flags.
module dvp_capture_rgb565
  import dvp_capture_rgb565_pkg::*;
#(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int FRAME_SKIP = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_done,
  input  logic                 cmos_vsync,
  input  logic                 cmos_href,
  input  logic [7:0]           cmos_d,
  dvp_capture_rgb565_if.master pix,
  output logic                 line_err,
  output logic                 frame_err,
  output cap_state_t           fsm_state
);

  localparam logic [CNT_W-1:0] H_LIM     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LIM     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(FRAME_SKIP - 1);

  logic             vs_q, vs_q2, hr_q, hr_q2;
  logic [7:0]       d_q;
  logic             vs_fall, vs_rise, hr_rise, hr_fall;
  cap_state_t       state;
  logic [CNT_W-1:0] skip_cnt, x_cnt, y_cnt, line_px;
  logic             pack_en, pair_valid, odd_err;
  logic [15:0]      pair_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
      hr_q  <= 1'b0;
      hr_q2 <= 1'b0;
      d_q   <= 8'h00;
    end else begin
      vs_q  <= cmos_vsync;
      vs_q2 <= vs_q;
      hr_q  <= cmos_href;
      hr_q2 <= hr_q;
      d_q   <= cmos_d;
    end
  end

  assign vs_fall = vs_q2 & ~vs_q;
  assign vs_rise = ~vs_q2 & vs_q;
  assign hr_rise = ~hr_q2 & hr_q;
  assign hr_fall = hr_q2 & ~hr_q;
  assign pack_en = (state == ACTIVE) && cfg_done;

  dvp_byte_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .en         (pack_en),
    .href       (hr_q),
    .href_rise  (hr_rise),
    .href_fall  (hr_fall),
    .d          (d_q),
    .pair_valid (pair_valid),
    .pair_data  (pair_data),
    .odd_err    (odd_err)
  );

  // The line's last pixel and its href fall land in the same cycle.
  assign line_px   = pair_valid ? sat_inc(x_cnt) : x_cnt;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT_CFG;
      skip_cnt        <= '0;
      x_cnt           <= '0;
      y_cnt           <= '0;
      pix.pix_valid   <= 1'b0;
      pix.pix_data    <= 16'h0000;
      pix.pix_x       <= '0;
      pix.pix_y       <= '0;
      pix.frame_start <= 1'b0;
      pix.frame_end   <= 1'b0;
      line_err        <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      pix.pix_valid   <= 1'b0;
      pix.frame_start <= 1'b0;
      pix.frame_end   <= 1'b0;
      if (odd_err) line_err <= 1'b1;

      if (!cfg_done) begin
        state    <= WAIT_CFG;
        skip_cnt <= '0;
      end else begin
        case (state)
          WAIT_CFG: begin
            state    <= SKIP;
            skip_cnt <= '0;
          end
          SKIP: begin
            if (FRAME_SKIP == 0) begin
              state <= WAIT_VS;
            end else if (vs_fall) begin
              skip_cnt <= sat_inc(skip_cnt);
              if (skip_cnt == SKIP_LAST) state <= WAIT_VS;
            end
          end
          WAIT_VS: begin
            if (vs_fall) state <= ACTIVE;
          end
          ACTIVE: begin
            if (pair_valid) begin
              x_cnt <= sat_inc(x_cnt);
              if (x_cnt < H_LIM && y_cnt < V_LIM) begin
                pix.pix_valid   <= 1'b1;
                pix.pix_data    <= pair_data;
                pix.pix_x       <= x_cnt;
                pix.pix_y       <= y_cnt;
                pix.frame_start <= (x_cnt == '0) && (y_cnt == '0);
              end
            end
            if (hr_fall) begin
              x_cnt <= '0;
              y_cnt <= sat_inc(y_cnt);
              if (line_px != H_LIM) line_err <= 1'b1;
            end
            if (vs_rise) begin
              state         <= WAIT_VS;
              pix.frame_end <= 1'b1;
              if (y_cnt != V_LIM) frame_err <= 1'b1;
            end
          end
          default: state <= WAIT_CFG;
        endcase
      end

      if (vs_fall) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture_rgb565.sv
// Directed bench for dvp_capture_rgb565 on a reduced 16x6 geometry with a
// two-frame skip.
module tb_dvp_capture_rgb565;
  import dvp_capture_rgb565_pkg::*;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int FS = 2;

  // clock / reset
  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       cfg_done   = 1'b0;
  logic       cmos_vsync = 1'b1;
  logic       cmos_href  = 1'b0;
  logic [7:0] cmos_d     = 8'h00;
  logic       line_err, frame_err;
  cap_state_t fsm_state;

  dvp_capture_rgb565_if pif ();

  dvp_capture_rgb565 #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FRAME_SKIP (FS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_done   (cfg_done),
    .cmos_vsync (cmos_vsync),
    .cmos_href  (cmos_href),
    .cmos_d     (cmos_d),
    .pix        (pif.master),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pv    = 0;
  int          n_fs    = 0;
  int          n_fe    = 0;
  int          seed    = 0;
  bit          ov_en   = 1'b0;
  logic [7:0]  prev_b  = 8'h00;
  logic [35:0] exp_q[$];

  // scoreboard: every pixel must match the next expected {y, x, data}
  always @(negedge clk) begin
    logic [35:0] e;
    if (pif.pix_valid) begin
      n_pv++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL pix_unexpected: observed y=%0d x=%0d data=%04h, expected no pixel",
               pif.pix_y, pif.pix_x, pif.pix_data);
      end else begin
        e = exp_q.pop_front();
        assert ({pif.pix_y, pif.pix_x, pif.pix_data} === e) else begin
          n_fail++;
          $error("FAIL pix: observed y=%0d x=%0d data=%04h, expected y=%0d x=%0d data=%04h",
                 pif.pix_y, pif.pix_x, pif.pix_data, e[35:26], e[25:16], e[15:0]);
        end
        n_tests++;
        assert (pif.frame_start === (e[35:16] == 20'd0)) else begin
          n_fail++;
          $error("FAIL frame_start_pixel: observed %0b at y=%0d x=%0d", pif.frame_start,
                 e[35:26], e[25:16]);
        end
      end
    end else if (pif.frame_start) begin
      n_tests++;
      n_fail++;
      $error("FAIL frame_start_alone: observed 1, expected 0 without pix_valid");
    end
    if (pif.frame_start) n_fs++;
    if (pif.frame_end) n_fe++;
  end

  // driver tasks
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] pat(input int row, input int k);
    if (ov_en && row == 0 && k == 0) return 8'hF8;
    if (ov_en && row == 0 && k == 1) return 8'h1F;
    return 8'((row * 29 + k * 7 + seed) % 256);
  endfunction

  task automatic send_byte(input int row, input int k, input bit cap);
    cmos_href = 1'b1;
    cmos_d    = pat(row, k);
    if (cap && (k % 2 == 1) && row < V && k / 2 < H)
      exp_q.push_back({10'(row), 10'(k / 2), prev_b, cmos_d});
    prev_b = cmos_d;
    tick(1);
  endtask

  task automatic send_line(input int row, input int k0, input int nbytes, input bit cap);
    for (int k = k0; k < nbytes; k++) send_byte(row, k, cap);
    cmos_href = 1'b0;
    cmos_d    = 8'h00;
    tick(4);
  endtask

  task automatic send_frame(input int nlines, input bit cap);
    cmos_vsync = 1'b0;
    tick(3);
    for (int r = 0; r < nlines; r++) send_line(r, 0, 2 * H, cap);
    cmos_vsync = 1'b1;
    tick(4);
  endtask

  task automatic clr_counts();
    n_pv = 0;
    n_fs = 0;
    n_fe = 0;
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_pix_valid", 36'(pif.pix_valid), 36'(0));
    chk("rst_pix_data", 36'(pif.pix_data), 36'(0));
    chk("rst_pix_xy", 36'({pif.pix_x, pif.pix_y}), 36'(0));
    chk("rst_pulses", 36'({pif.frame_start, pif.frame_end}), 36'(0));
    chk("rst_flags", 36'({line_err, frame_err}), 36'(0));
    chk("rst_state", 36'(fsm_state), 36'(WAIT_CFG));

    // skip two frames, capture the third
    rst = 1'b0;
    cfg_done = 1'b1;
    tick(2);
    chk("cfg_to_skip", 36'(fsm_state), 36'(SKIP));
    clr_counts();
    seed = 17;
    send_frame(V, 1'b0);
    chk("skip_after_f1", 36'(fsm_state), 36'(SKIP));
    send_frame(V, 1'b0);
    chk("waitvs_after_f2", 36'(fsm_state), 36'(WAIT_VS));
    chk("no_pix_in_skip", 36'(n_pv), 36'(0));

    cmos_vsync = 1'b0;
    tick(3);
    ov_en = 1'b1;
    send_byte(0, 0, 1'b1);
    send_byte(0, 1, 1'b1);
    chk("lat_edge0", 36'(pif.pix_valid), 36'(0));
    send_byte(0, 2, 1'b1);
    chk("lat_edge1", 36'(pif.pix_valid), 36'(0));
    send_byte(0, 3, 1'b1);
    chk("lat_edge2_valid", 36'(pif.pix_valid), 36'(1));
    chk("first_pix_data", 36'(pif.pix_data), 36'(16'hF81F));
    chk("first_pix_xy", 36'({pif.pix_x, pif.pix_y}), 36'(0));
    chk("first_frame_start", 36'(pif.frame_start), 36'(1));
    send_line(0, 4, 2 * H, 1'b1);
    ov_en = 1'b0;
    for (int r = 1; r < V; r++) send_line(r, 0, 2 * H, 1'b1);
    cmos_vsync = 1'b1;
    tick(4);
    chk("f3_pix_count", 36'(n_pv), 36'(H * V));
    chk("f3_frame_start", 36'(n_fs), 36'(1));
    chk("f3_frame_end", 36'(n_fe), 36'(1));
    chk("f3_flags", 36'({line_err, frame_err}), 36'(0));
    chk("f3_queue_empty", 36'(exp_q.size()), 36'(0));

    // line of 2H+1 bytes
    clr_counts();
    seed = 101;
    cmos_vsync = 1'b0;
    tick(3);
    send_line(0, 0, 2 * H + 1, 1'b1);
    chk("odd_line_err", 36'(line_err), 36'(1));
    for (int r = 1; r < V; r++) send_line(r, 0, 2 * H, 1'b1);
    cmos_vsync = 1'b1;
    tick(4);
    chk("odd_pix_count", 36'(n_pv), 36'(H * V));
    chk("odd_frame_err", 36'(frame_err), 36'(0));

    // reset in the middle of a line
    clr_counts();
    seed = 55;
    cmos_vsync = 1'b0;
    tick(3);
    for (int k = 0; k < 10; k++) send_byte(0, k, k < 8);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_pix_valid", 36'(pif.pix_valid), 36'(0));
    chk("mid_rst_pix_data", 36'(pif.pix_data), 36'(0));
    chk("mid_rst_pix_xy", 36'({pif.pix_x, pif.pix_y}), 36'(0));
    chk("mid_rst_flags", 36'({line_err, frame_err}), 36'(0));
    chk("mid_rst_state", 36'(fsm_state), 36'(WAIT_CFG));
    chk("mid_rst_pre_pix", 36'(n_pv), 36'(4));
    rst = 1'b0;
    clr_counts();
    send_line(0, 10, 2 * H, 1'b0);
    for (int r = 1; r < V; r++) send_line(r, 0, 2 * H, 1'b0);
    cmos_vsync = 1'b1;
    tick(4);
    chk("post_rst_skip", 36'(fsm_state), 36'(SKIP));
    send_frame(V, 1'b0);
    send_frame(V, 1'b0);
    chk("post_rst_waitvs", 36'(fsm_state), 36'(WAIT_VS));
    chk("post_rst_no_pix", 36'({n_pv[15:0], n_fe[15:0]}), 36'(0));

    // short frame
    clr_counts();
    seed = 200;
    send_frame(V - 2, 1'b1);
    chk("short_pix_count", 36'(n_pv), 36'(H * (V - 2)));
    chk("short_frame_end", 36'(n_fe), 36'(1));
    chk("short_frame_err", 36'(frame_err), 36'(1));
    chk("short_line_err", 36'(line_err), 36'(0));

    // cfg_done dropped mid-frame
    clr_counts();
    seed = 9;
    cmos_vsync = 1'b0;
    tick(3);
    for (int r = 0; r < 3; r++) send_line(r, 0, 2 * H, 1'b1);
    for (int k = 0; k < 6; k++) send_byte(3, k, k < 4);
    chk("drop_pv_before", 36'(pif.pix_valid), 36'(1));
    cfg_done = 1'b0;
    send_byte(3, 6, 1'b0);
    chk("drop_pv_after", 36'(pif.pix_valid), 36'(0));
    chk("drop_state", 36'(fsm_state), 36'(WAIT_CFG));
    send_line(3, 7, 2 * H, 1'b0);
    for (int r = 4; r < V; r++) send_line(r, 0, 2 * H, 1'b0);
    cmos_vsync = 1'b1;
    tick(4);
    chk("drop_no_frame_end", 36'(n_fe), 36'(0));
    chk("drop_pix_count", 36'(n_pv), 36'(3 * H + 2));
    cfg_done = 1'b1;
    tick(2);
    chk("recfg_skip", 36'(fsm_state), 36'(SKIP));
    clr_counts();
    send_frame(V, 1'b0);
    chk("recfg_skip_f1", 36'(fsm_state), 36'(SKIP));
    send_frame(V, 1'b0);
    chk("recfg_waitvs_f2", 36'(fsm_state), 36'(WAIT_VS));
    send_frame(V, 1'b1);
    chk("recfg_pix_count", 36'(n_pv), 36'(H * V));
    chk("recfg_frame_end", 36'(n_fe), 36'(1));
    chk("final_queue_empty", 36'(exp_q.size()), 36'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_capture_rgb565.md
DVP_CAPTURE_RGB565 -- requirements
Module: dvp_capture_rgb565

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272: active lines per frame.
REQ-003 SHALL have parameter FRAME_SKIP, default 10: frames discarded after configuration completes.
REQ-004 SHALL have port clk  input  1: camera pixel clock (PCLK); the only clock.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port cfg_done  input  1: sensor register configuration complete (level).
REQ-007 SHALL have port cmos_vsync  input  1: frame sync, high during vertical blanking.
REQ-008 SHALL have port cmos_href  input  1: line valid, high during active bytes.
REQ-009 SHALL have port cmos_d  input  8: DVP data byte.
REQ-010 SHALL have port pix_valid  output  1: pix_data, pix_x and pix_y valid this cycle.
REQ-011 SHALL have port pix_data  output  16: RGB565 pixel, first byte in [15:8], second byte in [7:0].
REQ-012 SHALL have port pix_x  output  10: column of the current pixel, 0-based.
REQ-013 SHALL have port pix_y  output  10: row of the current pixel, 0-based.
REQ-014 SHALL have port frame_start  output  1: one-cycle pulse, first pixel of a captured frame.
REQ-015 SHALL have port frame_end  output  1: one-cycle pulse at the vsync rising edge that closes a captured frame.
REQ-016 SHALL have port line_err  output  1: sticky flag, set on any line-length or odd-byte fault.
REQ-017 SHALL have port frame_err  output  1: sticky flag, set when a frame's line count is not V_ACTIVE.

Function
REQ-018 SHALL register cmos_vsync, cmos_href and cmos_d once before any use.
REQ-019 SHALL implement FSM states WAIT_CFG, SKIP, WAIT_VS and ACTIVE.
REQ-020 WAIT_CFG SHALL go to SKIP on cfg_done=1.
REQ-021 SKIP SHALL count registered-vsync falling edges and go to WAIT_VS after FRAME_SKIP edges; with FRAME_SKIP=0 it SHALL go directly to WAIT_VS.
REQ-022 WAIT_VS SHALL go to ACTIVE on a registered-vsync falling edge.
REQ-023 ACTIVE SHALL return to WAIT_VS on the vsync rising edge and pulse frame_end in the same cycle.
REQ-024 In any state, cfg_done=0 SHALL force WAIT_CFG next cycle, drop pix_valid, and suppress frame_end.
REQ-025 In ACTIVE, bytes SHALL be paired while registered href=1; the byte toggle SHALL clear on every href rising edge.
REQ-026 pix_valid SHALL assert 2 clk edges after the edge that samples the second byte at the ports.
REQ-027 pix_x SHALL start at 0 each line, increment per pixel, and saturate at H_ACTIVE-1.
REQ-028 Pixels with column >= H_ACTIVE SHALL be dropped (no pix_valid).
REQ-029 pix_y SHALL increment on each href falling edge and clear on vsync falling edge.
REQ-030 Lines with row >= V_ACTIVE SHALL be dropped.
REQ-031 frame_start SHALL coincide with pix_valid for pixel (0,0) of each captured frame.
REQ-032 An href falling edge with an unpaired byte SHALL discard that byte and set line_err.
REQ-033 A completed line whose pixel count is not H_ACTIVE SHALL set line_err.
REQ-034 At frame_end, a line count not equal to V_ACTIVE SHALL set frame_err.
REQ-035 Outputs SHALL change only on clk rising edges; pix_data SHALL hold its last value when pix_valid=0.

Reset
REQ-036 rst=1 SHALL force WAIT_CFG, clear all counters and the skip count, and zero all outputs (pix_data=0, pix_x=0, pix_y=0, all flags 0) at the next edge.
REQ-037 line_err and frame_err SHALL clear only on rst.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding and the counter width constant (10).
REQ-039 A sub-module dvp_byte_pack SHALL perform byte pairing and odd-byte detection.

Verification
REQ-040 Bench SHALL cover: FRAME_SKIP=2, three 480x272 frames -> only frame 3 output, 130560 pix_valid cycles, one frame_start, one frame_end.
REQ-041 Bench SHALL cover: bytes 0xF8, 0x1F on the first pair -> pix_data=0xF81F at (0,0), 2 edges after 0x1F is sampled.
REQ-042 Bench SHALL cover: a line of 961 bytes -> 480 pixels output, line_err=1.
REQ-043 Bench SHALL cover: a frame of 270 lines -> frame_err=1 at frame_end, line_err=0.
REQ-044 Bench SHALL cover: cfg_done dropped at row 100 -> pix_valid=0 next cycle, no frame_end, FRAME_SKIP counted again after cfg_done returns.
REQ-045 Bench SHALL cover: rst mid-line -> all outputs 0 next cycle, flags cleared, capture resumes only via WAIT_CFG.
